// File: rtl/cba_pkg.sv
// Shared constants, state encoding and helpers for the nibble-serial carry-bypass adder.
package cba_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A nibble whose bits all propagate passes its carry-in straight through.
  function automatic logic prop_all_f(input logic [NIBBLE_W-1:0] x,
                                      input logic [NIBBLE_W-1:0] y);
    return (x ^ y) == {NIBBLE_W{1'b1}};
  endfunction

endpackage

// File: rtl/cba_nibble_slice.sv
// Combinational 4-bit carry-bypass adder slice: ripple sum, carry skips the
// chain when every bit position propagates.
module cba_nibble_slice
  import cba_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                prop_all
);

  logic [NIBBLE_W:0] c;

  assign prop_all = prop_all_f(a, b);

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    co = prop_all ? ci : c[NIBBLE_W];
  end

endmodule

// File: rtl/cba_serial_add_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle (LSB first) through a single
// carry-bypass slice. Optional propagate-all statistics: CBA_BYPASS_STATS_EN.
module cba_serial_add_ctrl
  import cba_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CBA_BYPASS_STATS_EN
  ,
  output logic [$clog2(WIDTH/4+1)-1:0] bypass_cnt
`endif
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_width_check
      $error("cba_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_sh, b_sh, sum_sh, sum_next, sum_q;
  logic                  carry_q, cout_q;
  logic [IW-1:0]         idx_q;
  logic                  accept, run_step, last_step;
  logic [NIBBLE_W-1:0]   slice_s;
  logic                  slice_co, slice_prop;

  // Valid/ready: a transfer happens on any rising edge where valid and ready
  // are both high; valid is held with its data until that edge, ready never
  // depends combinationally on valid.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign run_step  = (state_q == ST_RUN);
  assign last_step = run_step && (idx_q == IW'(NIB - 1));
  assign sum       = sum_q;
  assign cout      = cout_q;

  cba_nibble_slice u_slice (
    .a        (a_sh[NIBBLE_W-1:0]),
    .b        (b_sh[NIBBLE_W-1:0]),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .prop_all (slice_prop)
  );

  // New nibble enters at the top so the LSB nibble ends at bit 0 after NIB steps.
  assign sum_next = (sum_sh >> NIBBLE_W) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= cin;
      idx_q   <= '0;
    end else if (run_step) begin
      a_sh    <= a_sh >> NIBBLE_W;
      b_sh    <= b_sh >> NIBBLE_W;
      sum_sh  <= sum_next;
      carry_q <= slice_co;
      idx_q   <= idx_q + IW'(1);
      if (last_step) begin
        sum_q  <= sum_next;
        cout_q <= slice_co;
      end
    end
  end

`ifdef CBA_BYPASS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         bypass_cnt <= '0;
    else if (accept)                 bypass_cnt <= '0;
    else if (run_step && slice_prop) bypass_cnt <= bypass_cnt + 1'b1;
  end
`else
  logic slice_prop_unused;
  assign slice_prop_unused = slice_prop;
`endif

endmodule

// File: tb/tb_cba_serial_add_ctrl.sv
// Testbench for cba_serial_add_ctrl (WIDTH=16), with or without CBA_BYPASS_STATS_EN.
module tb_cba_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int W     = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, out_ready, cin;
  logic             in_ready, out_valid, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CBA_BYPASS_STATS_EN
  logic [2:0]       bypass_cnt;
  int               bp_q[$];
`endif

  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               bp;
    int               stall;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  cba_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout)
`ifdef CBA_BYPASS_STATS_EN
    ,
    .bypass_cnt (bypass_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci);
    return {1'b0, x} + {1'b0, y} + W'(ci);
  endfunction

  function automatic int model_bp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] p;
    int n;
    p = x ^ y;
    n = 0;
    for (int i = 0; i < NIB; i++) if (p[4*i +: 4] == 4'hF) n++;
    return n;
  endfunction

  // Presents one operand set at a negedge and returns after the accept edge.
  task automatic drive_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic [W-1:0] exp, input int exp_bp);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
    exp_q.push_back(exp);
`ifdef CBA_BYPASS_STATS_EN
    bp_q.push_back(exp_bp);
`else
    if (exp_bp < 0) $display("note: negative bypass expectation for %s", tag);
`endif
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int stall, input bit scramble);
    int lat;
    logic [W-1:0] exp;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (scramble) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(NIB));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, ".result"}, 32'({cout, sum}), 32'(exp));
`ifdef CBA_BYPASS_STATS_EN
    check({tag, ".bypass_cnt"}, 32'(bypass_cnt), (bp_q.size() > 0) ? 32'(bp_q.pop_front()) : 32'hFF);
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".stall_result"}, 32'({cout, sum}), 32'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".release_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] rx, ry;
    logic             rc;
    int               spurious;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout", 32'(cout), 32'd0);
`ifdef CBA_BYPASS_STATS_EN
    check("reset.bypass_cnt", 32'(bypass_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3, 0};
    vecs[2] = '{16'h00FF, 16'hFF00, 1'b0, 16'hFFFF, 1'b0, 4, 0};
    vecs[3] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 4, 0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 10};
    vecs[5] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 0, 0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 0, 2};
    vecs[7] = '{16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1, 4, 0};

    foreach (vecs[i]) begin
      drive_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
               {vecs[i].cout, vecs[i].sum}, vecs[i].bp);
      collect($sformatf("vec%0d", i), vecs[i].stall, 1'b0);
    end

    // Back-to-back random operations with input noise while busy.
    for (int i = 0; i < 12; i++) begin
      rx = WIDTH'($urandom);
      ry = (i % 3 == 0) ? ~rx : WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      drive_op($sformatf("rnd%0d", i), rx, ry, rc, model_add(rx, ry, rc), model_bp(rx, ry));
      collect($sformatf("rnd%0d", i), int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset during the second RUN cycle drops the operation.
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_run.out_valid", 32'(out_valid), 32'd0);
    check("rst_run.sum", 32'(sum), 32'd0);
    check("rst_run.cout", 32'(cout), 32'd0);
    check("rst_run.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("rst_run.no_result", 32'(spurious), 32'd0);
    drive_op("post_rst", 16'h0001, 16'h0001, 1'b0, {1'b0, 16'h0002}, 0);
    collect("post_rst", 0, 1'b0);

    // Reset while a nonzero result is waiting in DONE.
    drive_op("rst_done", 16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 0);
    spurious = 0;
    while (!out_valid && spurious < 50) begin
      @(negedge clk);
      spurious++;
    end
    check("rst_done.reached", 32'(out_valid), 32'd1);
    check("rst_done.sum_before", 32'(sum), 32'h5555);
    void'(exp_q.pop_back());
`ifdef CBA_BYPASS_STATS_EN
    void'(bp_q.pop_back());
`endif
    rst = 1'b1;
    #1;
    check("rst_done.out_valid", 32'(out_valid), 32'd0);
    check("rst_done.sum", 32'(sum), 32'd0);
    check("rst_done.cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cba_serial_add_ctrl.md
Name: cba_serial_add_ctrl

Overview:
- Sequencer that reuses one 4-bit carry-bypass adder slice to add WIDTH-bit operands, one nibble per cycle, LSB nibble first.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Owns the inter-nibble carry register, the operand/sum shift registers and the nibble counter.
- The slice itself is combinational and lives in the sub-module.

Parameters:
- WIDTH, 16: operand and sum width. Must be a multiple of 4 and at least 4; otherwise elaboration error.
- NIB, WIDTH/4: derived nibble count. Local parameter, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry out of the top nibble.
- bypass_cnt  output  $clog2(NIB+1)  present only with CBA_BYPASS_STATS_EN.

Behaviour:
- Reset, asynchronous on rst high: state=IDLE, sum=0, cout=0, out_valid=0, nibble counter=0, carry reg=0, shift regs=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready at an edge: latch a, b into shift registers, carry<=cin, idx<=0, go to RUN.
  - RUN: in_ready=0. Each cycle the slice adds a_sh[3:0] + b_sh[3:0] + carry. At the edge:
    - sum_sh shifts right by 4, with the slice sum inserted at [WIDTH-1:WIDTH-4].
    - a_sh and b_sh shift right by 4.
    - carry<=slice cout; idx<=idx+1.
    - When idx==NIB-1: sum<=final sum_sh, cout<=slice cout, out_valid<=1, go to DONE.
  - DONE: out_valid=1; sum and cout held stable. in_ready=0. When out_ready at an edge: out_valid<=0, go to IDLE.
- Latency: accept at edge k gives out_valid high after edge k+NIB (4 cycles for WIDTH=16).
- Throughput: one operation per NIB+2 cycles minimum. No overlap of accept and result; in_ready is 0 while out_valid=1.
- in_ready is a pure decode of state==IDLE (combinational, no input dependency).
- in_valid while not ready: ignored. a, b, cin are sampled only on the accept edge; later changes have no effect.
- out_valid held with out_ready low: stall indefinitely, outputs stable.
- All sums are modulo 2^WIDTH; overflow is reported only through cout.
- rst asserted mid-RUN or mid-DONE: operation dropped, no result produced, all outputs take reset values immediately.
- Slice carry-bypass: if (a_nib^b_nib)==4'hF, slice cout=carry-in; otherwise slice cout=ripple carry. This is functionally identical either way; the controller does not depend on which path is taken.

Optional Feature:
- Macro: CBA_BYPASS_STATS_EN.
- With it defined:
  - bypass_cnt port exists, reset 0.
  - Cleared to 0 on the accept edge.
  - Incremented on each RUN edge where the current nibble has propagate-all ((a^b)==4'hF).
  - Final value is valid and held while out_valid=1.
- Without it: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cba_pkg:
  - NIBBLE_W=4.
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - Function for the nibble propagate-all check.
- Sub-module cba_nibble_slice:
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, prop_all.
  - Purely combinational carry-bypass adder.
  - The controller instantiates it exactly once.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> after 4 cycles out_valid=1, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Check that carry ripples across all 4 nibbles.
- a=0x00FF, b=0xFF00:
  - cin=0 -> sum=0xFFFF, cout=0, bypass_cnt=4 (with macro).
  - cin=1 -> sum=0x0000, cout=1, bypass_cnt=4.
- Backpressure: complete an add with out_ready=0 for 10 cycles -> out_valid, sum, cout stable and in_ready=0 throughout. Raise out_ready -> IDLE next cycle, in_ready=1.
- Toggle in_valid and change a/b during RUN -> ignored; result matches operands latched at accept. Back-to-back ops yield exactly one result each, in order.
- Assert rst during the 2nd RUN cycle -> out_valid=0, sum=0, cout=0 at once. After release, a new add a=0x0001, b=0x0001 -> sum=0x0002.
